// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory-controller port between fetch and load/store
//
// Purpose: grants the single CPU-side memory port to either the instruction
// fetch requester (I) or the load/store requester (D), one transaction at a
// time, with round-robin fairness and a per-transaction timeout.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   i_req/i_addr               fetch request and address (held until i_ack)
//   i_ack/i_rdata/i_err        fetch completion pulse, data, timeout flag
//   d_req/d_addr/d_wdata/
//   d_wstrb/d_we               load/store request fields (held until d_ack)
//   d_ack/d_rdata/d_err        load/store completion pulse, data, timeout flag
//   m_addr/m_wdata/m_wstrb/
//   m_we/m_re                  registered request to the memory controller
//   m_ready/m_rdata            controller handshake and read data
//   busy                       high whenever not IDLE
//   last_grant                 0 = I granted last, 1 = D granted last
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic                d_we,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_we,
  output logic                m_re,
  input  logic                m_ready,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy,
  output logic                last_grant
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [15:0]         r_cnt;
  logic                r_last_grant;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [STRB_W-1:0]   r_m_wstrb;
  logic                r_m_we;
  logic                r_m_re;
  logic                r_i_ack;
  logic                r_i_err;
  logic [DATA_W-1:0]   r_i_rdata;
  logic                r_d_ack;
  logic                r_d_err;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_timeout;

  // Under contention the requester not served last wins; r_last_grant resets
  // to D so that I wins the first contention.
  assign w_grant_i = i_req & (~d_req | r_last_grant);
  assign w_grant_d = d_req & (~i_req | ~r_last_grant);
  assign w_timeout = (r_cnt == LP_TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant_i || w_grant_d) w_next_state = ST_ACCESS;
      ST_ACCESS: if (m_ready || w_timeout) w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // r_last_grant doubles as the owner of the transaction in flight, since it
  // is updated at the moment of grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_wstrb    <= '0;
      r_m_we       <= 1'b0;
      r_m_re       <= 1'b0;
      r_i_ack      <= 1'b0;
      r_i_err      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
      r_d_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_m_addr     <= d_addr;
            r_m_wdata    <= d_wdata;
            r_m_wstrb    <= d_wstrb;
            r_m_we       <= d_we;
            r_m_re       <= ~d_we;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
          end else if (w_grant_i) begin
            r_m_addr     <= i_addr;
            r_m_wdata    <= '0;
            r_m_wstrb    <= '0;
            r_m_we       <= 1'b0;
            r_m_re       <= 1'b1;
            r_last_grant <= 1'b0;
            r_cnt        <= '0;
          end
        end
        ST_ACCESS: begin
          if (m_ready) begin
            r_m_we <= 1'b0;
            r_m_re <= 1'b0;
            if (r_last_grant) begin
              r_d_rdata <= m_rdata;
              r_d_ack   <= 1'b1;
            end else begin
              r_i_rdata <= m_rdata;
              r_i_ack   <= 1'b1;
            end
          end else if (w_timeout) begin
            // Abort: return zero data flagged as an error.
            r_m_we <= 1'b0;
            r_m_re <= 1'b0;
            if (r_last_grant) begin
              r_d_rdata <= '0;
              r_d_err   <= 1'b1;
              r_d_ack   <= 1'b1;
            end else begin
              r_i_rdata <= '0;
              r_i_err   <= 1'b1;
              r_i_ack   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          r_i_ack <= 1'b0;
          r_i_err <= 1'b0;
          r_d_ack <= 1'b0;
          r_d_err <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign i_ack      = r_i_ack;
  assign i_err      = r_i_err;
  assign i_rdata    = r_i_rdata;
  assign d_ack      = r_d_ack;
  assign d_err      = r_d_err;
  assign d_rdata    = r_d_rdata;
  assign m_addr     = r_m_addr;
  assign m_wdata    = r_m_wdata;
  assign m_wstrb    = r_m_wstrb;
  assign m_we       = r_m_we;
  assign m_re       = r_m_re;
  assign busy       = (r_state != ST_IDLE);
  assign last_grant = r_last_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_we = 1'b0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_we;
  logic        m_re;
  logic        m_ready = 1'b1;
  logic [31:0] m_rdata = '0;
  logic        busy;
  logic        last_grant;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_we(d_we),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_we(m_we), .m_re(m_re),
    .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy), .last_grant(last_grant)
  );

  typedef struct packed {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_we;
    logic        m_ready;
    logic [31:0] m_rdata;
  } ins_t;

  typedef struct packed {
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        m_re;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        busy;
    logic        last_grant;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t ex;
  } vec_t;

  vec_t vecs[$];

  function automatic ins_t mki(logic ir, logic [31:0] ia, logic dr, logic [31:0] da,
                               logic [31:0] dwd, logic [3:0] dws, logic dwe,
                               logic mr, logic [31:0] mrd);
    return '{ir, ia, dr, da, dwd, dws, dwe, mr, mrd};
  endfunction

  function automatic outs_t mke(logic ia, logic ie, logic [31:0] ird,
                                logic da, logic de, logic [31:0] drd,
                                logic re, logic we, logic [31:0] ma,
                                logic [31:0] mwd, logic [3:0] mws,
                                logic bz, logic lg);
    return '{ia, ie, ird, da, de, drd, re, we, ma, mwd, mws, bz, lg};
  endfunction

  function automatic outs_t get_outs();
    return '{i_ack, i_err, i_rdata, d_ack, d_err, d_rdata, m_re, m_we,
             m_addr, m_wdata, m_wstrb, busy, last_grant};
  endfunction

  task automatic apply(input ins_t v);
    i_req   = v.i_req;
    i_addr  = v.i_addr;
    d_req   = v.d_req;
    d_addr  = v.d_addr;
    d_wdata = v.d_wdata;
    d_wstrb = v.d_wstrb;
    d_we    = v.d_we;
    m_ready = v.m_ready;
    m_rdata = v.m_rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  ins_t idle_in;
  ins_t s_in;
  ins_t w_in;
  int   re_cycles;

  initial begin
    idle_in = mki(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Single fetch from 0x40 returning 0x13.
    vecs.push_back('{mki(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h13), mke(0,0,32'h0,  0,0,32'h0, 1,0,32'h40,0,0,1,0)});
    vecs.push_back('{mki(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h13), mke(1,0,32'h13, 0,0,32'h0, 0,0,32'h40,0,0,1,0)});
    vecs.push_back('{mki(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h13), mke(0,0,32'h13, 0,0,32'h0, 0,0,32'h40,0,0,0,0)});
    vecs.push_back('{idle_in,                                  mke(0,0,32'h13, 0,0,32'h0, 0,0,32'h40,0,0,0,0)});
    // Byte store; write still captures m_rdata into d_rdata.
    s_in = mki(0, 0, 1, 32'h2000_0000, 32'h41, 4'b0001, 1, 1, 32'h5555_5555);
    vecs.push_back('{s_in,    mke(0,0,32'h13, 0,0,32'h0,         0,1,32'h2000_0000,32'h41,4'h1,1,1)});
    vecs.push_back('{s_in,    mke(0,0,32'h13, 1,0,32'h5555_5555, 0,0,32'h2000_0000,32'h41,4'h1,1,1)});
    vecs.push_back('{s_in,    mke(0,0,32'h13, 0,0,32'h5555_5555, 0,0,32'h2000_0000,32'h41,4'h1,0,1)});
    vecs.push_back('{idle_in, mke(0,0,32'h13, 0,0,32'h5555_5555, 0,0,32'h2000_0000,32'h41,4'h1,0,1)});
    // Contention: both held high, grants I, D, I, D.
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'h0),  mke(0,0,32'h13,0,0,32'h5555_5555,1,0,32'h100,0,0,1,0)});
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'hA0), mke(1,0,32'hA0,0,0,32'h5555_5555,0,0,32'h100,0,0,1,0)});
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'h0),  mke(0,0,32'hA0,0,0,32'h5555_5555,0,0,32'h100,0,0,0,0)});
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'h0),  mke(0,0,32'hA0,0,0,32'h5555_5555,1,0,32'h3000_0000,32'h77,4'hF,1,1)});
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'hB0), mke(0,0,32'hA0,1,0,32'hB0,0,0,32'h3000_0000,32'h77,4'hF,1,1)});
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'h0),  mke(0,0,32'hA0,0,0,32'hB0,0,0,32'h3000_0000,32'h77,4'hF,0,1)});
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'h0),  mke(0,0,32'hA0,0,0,32'hB0,1,0,32'h100,0,0,1,0)});
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'hA1), mke(1,0,32'hA1,0,0,32'hB0,0,0,32'h100,0,0,1,0)});
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'h0),  mke(0,0,32'hA1,0,0,32'hB0,0,0,32'h100,0,0,0,0)});
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'h0),  mke(0,0,32'hA1,0,0,32'hB0,1,0,32'h3000_0000,32'h77,4'hF,1,1)});
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'hB1), mke(0,0,32'hA1,1,0,32'hB1,0,0,32'h3000_0000,32'h77,4'hF,1,1)});
    vecs.push_back('{mki(1,32'h100,1,32'h3000_0000,32'h77,4'hF,0,1,32'h0),  mke(0,0,32'hA1,0,0,32'hB1,0,0,32'h3000_0000,32'h77,4'hF,0,1)});
    // Wait states: four ACCESS cycles with m_ready low, then 0xDEADBEEF.
    w_in = mki(0, 0, 1, 32'h4000_0000, 32'h0, 4'hF, 0, 0, 32'h0);
    for (int k = 0; k < 5; k++)
      vecs.push_back('{w_in, mke(0,0,32'hA1,0,0,32'hB1,1,0,32'h4000_0000,0,4'hF,1,1)});
    vecs.push_back('{mki(0,0,1,32'h4000_0000,0,4'hF,0,1,32'hDEAD_BEEF), mke(0,0,32'hA1,1,0,32'hDEAD_BEEF,0,0,32'h4000_0000,0,4'hF,1,1)});
    vecs.push_back('{mki(0,0,1,32'h4000_0000,0,4'hF,0,1,32'h0),         mke(0,0,32'hA1,0,0,32'hDEAD_BEEF,0,0,32'h4000_0000,0,4'hF,0,1)});

    // Reset state.
    apply(idle_in);
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_state", 160'(get_outs()), 160'(mke(0,0,0,0,0,0,0,0,0,0,0,0,1)));
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      apply(vecs[i].in);
      tick();
      chk($sformatf("vec%0d", i), 160'(get_outs()), 160'(vecs[i].ex));
    end
    apply(idle_in);
    tick();

    // Timeout: m_ready held low, m_re must stay up exactly TIMEOUT cycles.
    i_req = 1'b1; i_addr = 32'h80; m_ready = 1'b0; m_rdata = 32'h1234_5678;
    tick();
    re_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (m_re !== 1'b1) break;
      re_cycles++;
      tick();
    end
    chk("timeout_re_cycles", 160'(re_cycles), 160'(8));
    chk("timeout_resp", 160'({i_ack, i_err, i_rdata, d_ack, d_err, m_re, m_we}),
        160'({1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}));
    tick();
    i_req = 1'b0; m_ready = 1'b1;
    chk("timeout_done", 160'({i_ack, i_err, busy}), 160'(3'b000));
    // Next request proceeds normally.
    i_req = 1'b1; i_addr = 32'h84; m_rdata = 32'h99;
    tick();
    tick();
    chk("after_timeout", 160'({i_ack, i_err, i_rdata}), 160'({1'b1, 1'b0, 32'h99}));
    tick();
    i_req = 1'b0;
    tick();

    // Reset pulse mid-clock while a load is stalled in ACCESS.
    d_req = 1'b1; d_addr = 32'h5000_0000; d_we = 1'b0; d_wstrb = 4'hF; m_ready = 1'b0;
    tick();
    chk("pre_reset_access", 160'({busy, m_re}), 160'(2'b11));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clear", 160'(get_outs()), 160'(mke(0,0,0,0,0,0,0,0,0,0,0,0,1)));
    d_req = 1'b0;
    tick();
    chk("reset_hold_dack", 160'({d_ack, m_re, m_we, busy}), 160'(4'b0000));
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("post_reset%0d", k), 160'({d_ack, d_err, m_re, m_we, busy}), 160'(5'b00000));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
